// File: rtl/prbs_pkg.sv
// prbs_pkg
// Shared definitions for the 8-bit Fibonacci LFSR pattern generator and
// checker, so both ends agree on one polynomial and one state encoding.
//   prbs_state_t : checker FSM states, encoding is visible on the debug port
//   PRBS_WIDTH   : default LFSR length
//   PRBS_TAPS    : default feedback mask, x^8+x^6+x^5+x^4+1 (period 255)
package prbs_pkg;

    typedef enum logic [1:0] {
        ST_SEED   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } prbs_state_t;

    localparam int         PRBS_WIDTH = 8;
    localparam logic [7:0] PRBS_TAPS  = 8'hB8;

endpackage

// File: rtl/sat_counter.sv
// sat_counter
// Saturating up-counter with synchronous clear. Clear wins over increment,
// and a clear coinciding with an increment leaves the count at one, so the
// event that arrives with the clear is not lost.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : count one event this cycle
//   clr        : synchronous clear
//   count      : current total, sticks at all-ones
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? CNT_W'(1) : '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/prbs_checker.sv
// prbs_checker
// Serial receiver for the Fibonacci LFSR pattern (s_next = {s, ^(s & TAPS)},
// emitted bit = feedback bit). It seeds its shift register from the incoming
// stream, verifies a run of correct predictions, then locks and free-runs a
// local reference while counting bit errors.
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid   : in_bit carries a new sample this cycle
//   in_bit     : received serial bit
//   clr        : synchronous clear of err_count (lock unaffected)
//   locked     : pattern lock
//   err_pulse  : one-cycle strobe per counted error
//   err_count  : saturating error total
//   state      : FSM state for debug (SEED=0, VERIFY=1, LOCKED=2)
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int               WIDTH    = PRBS_WIDTH,
    parameter logic [WIDTH-1:0] TAPS     = WIDTH'(PRBS_TAPS),
    parameter int               LOCK_CNT = 16,
    parameter int               LOSS_CNT = 4,
    parameter int               CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [1:0]       state
);

    localparam int SEED_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int MISS_W  = $clog2(LOSS_CNT + 1);

    prbs_state_t        st;
    logic [WIDTH-1:0]   r;
    logic [SEED_W-1:0]  seed_cnt;
    logic [MATCH_W-1:0] match_cnt;
    logic [MISS_W-1:0]  miss_cnt;

    logic             pred;
    logic             hit;
    logic [WIDTH-1:0] r_rx;
    logic [WIDTH-1:0] r_pred;
    logic             err_inc;

    // Prediction of the next received bit from the last WIDTH bits.
    assign pred   = ^(r & TAPS);
    assign hit    = (in_bit == pred);
    // While acquiring, the received bit enters the register; once locked the
    // prediction does, so corrupted bits cannot pollute the reference.
    assign r_rx   = {r[WIDTH-2:0], in_bit};
    assign r_pred = {r[WIDTH-2:0], pred};

    assign err_inc = in_valid && (st == ST_LOCKED) && !hit;
    assign state   = st;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= ST_SEED;
            r         <= '0;
            seed_cnt  <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            if (in_valid) begin
                case (st)
                    ST_SEED: begin
                        r <= r_rx;
                        if (seed_cnt == SEED_W'(WIDTH - 1)) begin
                            seed_cnt <= '0;
                            // An all-zero register is the LFSR lock-up state
                            // and predicts nothing useful; keep seeding.
                            if (r_rx != '0) begin
                                st        <= ST_VERIFY;
                                match_cnt <= '0;
                            end
                        end else begin
                            seed_cnt <= seed_cnt + SEED_W'(1);
                        end
                    end
                    ST_VERIFY: begin
                        r <= r_rx;
                        if (hit) begin
                            match_cnt <= match_cnt + MATCH_W'(1);
                            if (match_cnt == MATCH_W'(LOCK_CNT - 1)) begin
                                st       <= ST_LOCKED;
                                locked   <= 1'b1;
                                miss_cnt <= '0;
                            end
                        end else begin
                            st        <= ST_SEED;
                            seed_cnt  <= '0;
                            match_cnt <= '0;
                        end
                    end
                    ST_LOCKED: begin
                        r <= r_pred;
                        if (hit) begin
                            miss_cnt <= '0;
                        end else begin
                            err_pulse <= 1'b1;
                            if (miss_cnt == MISS_W'(LOSS_CNT - 1)) begin
                                st       <= ST_SEED;
                                locked   <= 1'b0;
                                seed_cnt <= '0;
                                miss_cnt <= '0;
                            end else begin
                                miss_cnt <= miss_cnt + MISS_W'(1);
                            end
                        end
                    end
                    default: begin
                        st       <= ST_SEED;
                        locked   <= 1'b0;
                        seed_cnt <= '0;
                    end
                endcase
            end
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (err_inc),
        .clr   (clr),
        .count (err_count)
    );

endmodule

// File: tb/tb_prbs_checker.sv
// Directed testbench for prbs_checker. A default instance and a CNT_W=4
// instance share the same stimulus; the second one shows counter saturation.
module tb_prbs_checker;
    import prbs_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_bit;
    logic        clr;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic [1:0]  state;
    logic        locked4;
    logic        err_pulse4;
    logic [3:0]  err_count4;
    logic [1:0]  state4;

    int checks = 0;
    int errors = 0;

    logic [7:0] gen_s;

    prbs_checker dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .clr       (clr),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .state     (state)
    );

    prbs_checker #(.CNT_W(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .clr       (clr),
        .locked    (locked4),
        .err_pulse (err_pulse4),
        .err_count (err_count4),
        .state     (state4)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        in_bit   = 1'b0;
        clr      = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // generator model: emitted bit is the feedback bit
    task automatic gen_next(output logic b);
        logic fb;
        fb    = ^(gen_s & 8'hB8);
        gen_s = {gen_s[6:0], fb};
        b     = fb;
    endtask

    // drivers: inputs change at negedge, outputs observed 1 time unit after posedge
    task automatic send(input logic b, input logic c);
        @(negedge clk);
        in_valid = 1'b1;
        in_bit   = b;
        clr      = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic c);
        @(negedge clk);
        in_valid = 1'b0;
        clr      = c;
        @(posedge clk);
        #1;
    endtask

    task automatic send_clean(input int n, output int pulses);
        logic b;
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            gen_next(b);
            send(b, 1'b0);
            if (err_pulse) pulses++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %0b want 0", locked); end
        checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL reset_err_pulse got %0b want 0", err_pulse); end
        checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL reset_err_count got %0d want 0", err_count); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
    endtask

    task automatic test_lock();
        logic b;
        int   p;
        gen_s = 8'h01;
        for (int i = 1; i <= 24; i++) begin
            gen_next(b);
            send(b, 1'b0);
            if (i == 8) begin
                checks++; if (state !== 2'd1) begin errors++; $display("FAIL lock_verify_state got %0d want 1", state); end
            end
            if (i == 23) begin
                checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_early got %0b want 0", locked); end
            end
            if (i == 24) begin
                checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_at_24 got %0b want 1", locked); end
                checks++; if (state !== 2'd2) begin errors++; $display("FAIL lock_state got %0d want 2", state); end
            end
        end
        send_clean(1000, p);
        checks++; if (p !== 0) begin errors++; $display("FAIL clean_pulses got %0d want 0", p); end
        checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL clean_err_count got %0d want 0", err_count); end
        checks++; if (locked !== 1'b1 || locked4 !== 1'b1) begin errors++; $display("FAIL clean_locked got %0b/%0b want 1/1", locked, locked4); end
    endtask

    task automatic test_single_error();
        logic b;
        int   p;
        gen_next(b);
        send(~b, 1'b0);
        checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL single_pulse got %0b want 1", err_pulse); end
        checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL single_count got %0d want 1", err_count); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL single_locked got %0b want 1", locked); end
        idle(1'b0);
        checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL single_pulse_width got %0b want 0", err_pulse); end
        send_clean(50, p);
        checks++; if (p !== 0) begin errors++; $display("FAIL single_after_pulses got %0d want 0", p); end
        checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL single_after_count got %0d want 1", err_count); end
    endtask

    task automatic test_burst();
        logic b;
        int   p;
        idle(1'b1);
        checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL clr_count got %0d want 0", err_count); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL clr_locked got %0b want 1", locked); end
        for (int k = 1; k <= 4; k++) begin
            gen_next(b);
            send(~b, 1'b0);
            checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL burst_pulse_%0d got %0b want 1", k, err_pulse); end
            if (k == 3) begin
                checks++; if (locked !== 1'b1) begin errors++; $display("FAIL burst_locked_3 got %0b want 1", locked); end
            end
        end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL burst_loss got %0b want 0", locked); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL burst_state got %0d want 0", state); end
        checks++; if (err_count !== 16'd4) begin errors++; $display("FAIL burst_count got %0d want 4", err_count); end
        send_clean(23, p);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL relock_early got %0b want 0", locked); end
        send_clean(1, p);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL relock got %0b want 1", locked); end
        checks++; if (err_count !== 16'd4) begin errors++; $display("FAIL relock_count got %0d want 4", err_count); end
    endtask

    task automatic test_zero_stream();
        int bad;
        do_reset();
        bad = 0;
        for (int i = 0; i < 500; i++) begin
            send(1'b0, 1'b0);
            if (locked !== 1'b0 || state !== 2'd0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL zero_stream_bad_cycles got %0d want 0", bad); end
        checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL zero_stream_count got %0d want 0", err_count); end
    endtask

    task automatic test_gapped();
        logic b;
        int   nvalid;
        int   pulses;
        int   p;
        do_reset();
        gen_s  = 8'h01;
        nvalid = 0;
        pulses = 0;
        for (int cyc = 0; cyc < 5000 && nvalid < 200; cyc++) begin
            if ($urandom_range(0, 9) < 3) begin
                gen_next(b);
                send(b, 1'b0);
                nvalid++;
                if (err_pulse) pulses++;
                if (nvalid == 23) begin
                    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL gap_early got %0b want 0", locked); end
                end
                if (nvalid == 24) begin
                    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL gap_lock got %0b want 1", locked); end
                end
            end else begin
                idle(1'b0);
            end
        end
        checks++; if (nvalid !== 200) begin errors++; $display("FAIL gap_budget got %0d want 200", nvalid); end
        checks++; if (pulses !== 0 || err_count !== 16'd0) begin errors++; $display("FAIL gap_errors got %0d/%0d want 0/0", pulses, err_count); end
        gen_next(b);
        send(~b, 1'b0);
        send_clean(5, p);
        checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL gap_err_count got %0d want 1", err_count); end
        gen_next(b);
        send(~b, 1'b1);
        checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL clr_and_err got %0d want 1", err_count); end
        checks++; if (err_pulse !== 1'b1 || locked !== 1'b1) begin errors++; $display("FAIL clr_and_err_flags got %0b/%0b want 1/1", err_pulse, locked); end
    endtask

    task automatic test_saturation();
        logic b;
        int   p;
        for (int k = 0; k < 20; k++) begin
            gen_next(b);
            send(~b, 1'b0);
            send_clean(3, p);
        end
        checks++; if (err_count4 !== 4'd15) begin errors++; $display("FAIL sat_count4 got %0d want 15", err_count4); end
        checks++; if (err_count !== 16'd21) begin errors++; $display("FAIL sat_count16 got %0d want 21", err_count); end
        checks++; if (locked4 !== 1'b1) begin errors++; $display("FAIL sat_locked got %0b want 1", locked4); end
        // asynchronous reset in the middle of a valid cycle
        @(negedge clk);
        gen_next(b);
        in_valid = 1'b1;
        in_bit   = ~b;
        clr      = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (locked !== 1'b0 || locked4 !== 1'b0) begin errors++; $display("FAIL async_locked got %0b/%0b want 0/0", locked, locked4); end
        checks++; if (err_count !== 16'd0 || err_count4 !== 4'd0) begin errors++; $display("FAIL async_count got %0d/%0d want 0/0", err_count, err_count4); end
        checks++; if (err_pulse !== 1'b0 || err_pulse4 !== 1'b0) begin errors++; $display("FAIL async_pulse got %0b/%0b want 0/0", err_pulse, err_pulse4); end
        checks++; if (state !== 2'd0 || state4 !== 2'd0) begin errors++; $display("FAIL async_state got %0d/%0d want 0/0", state, state4); end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        idle(1'b0);
        checks++; if (err_count !== 16'd0 || state !== 2'd0) begin errors++; $display("FAIL post_reset got %0d/%0d want 0/0", err_count, state); end
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_bit   = 1'b0;
        clr      = 1'b0;
        gen_s    = 8'h01;
        test_reset();
        test_lock();
        test_single_error();
        test_burst();
        test_zero_stream();
        test_gapped();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
